// File: rtl/bcd_counter_bank_pkg.sv
// Shared constants and mode encoding for the BCD counter bank.
package bcd_counter_bank_pkg;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_MAX    = 2'd1,
        MODE_CARRY  = 2'd2
    } mode_e;

    // Limits above 9 are not valid BCD and behave as 9.
    function automatic logic [DIGIT_W-1:0] clamp_limit(input logic [DIGIT_W-1:0] lim);
        return (lim > BCD_MAX) ? BCD_MAX : lim;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Combinational next-value and wrap logic for one BCD digit.
module bcd_digit
    import bcd_counter_bank_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    input  logic               up,
    input  logic               down,
    input  logic [DIGIT_W-1:0] limit,
    input  logic               use_limit,
    output logic [DIGIT_W-1:0] next,
    output logic               wrap
);

    always_comb begin
        next = value;
        wrap = 1'b0;
        if (up) begin
            if (use_limit) begin
                if (value >= limit) begin
                    next = '0;
                    wrap = 1'b1;
                end else begin
                    next = value + 4'd1;
                end
            end else if (value == BCD_MAX) begin
                next = '0;
                wrap = 1'b1;
            end else if (value > BCD_MAX) begin
                next = '0;
            end else begin
                next = value + 4'd1;
            end
        end else if (down) begin
            if (value == 4'd0) begin
                next = use_limit ? limit : BCD_MAX;
                wrap = 1'b1;
            end else if (use_limit && value > limit) begin
                next = limit;
            end else if (value > BCD_MAX) begin
                next = BCD_MAX;
            end else begin
                next = value - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_bank.sv
// Bank of up/down BCD digit counters with single, max-limit and carry-chain modes.
module bcd_counter_bank
    import bcd_counter_bank_pkg::*;
#(
    parameter  int DIGITS = 6,
    localparam int SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cnt_up,
    input  logic                    cnt_down,
    input  logic                    clear,
    input  logic [SEL_W-1:0]        digit_sel,
    input  logic [DIGIT_W*DIGITS-1:0] max_in,
    input  logic                    carry_en,
    input  logic                    max_en,
    output logic [DIGIT_W*DIGITS-1:0] cnt_out,
    output logic                    ovf
);

    logic [DIGITS-1:0][DIGIT_W-1:0] cnt_q, nxt, lim_v;
    logic [DIGITS-1:0]              act, wrap, absorb;
    logic [DIGITS:0]                en_ext;
    logic                           up_ev, dn_ev, sel_ok, prop, ovf_q;
    mode_e                          mode;

    assign lim_v = max_in;

    always_comb begin
        up_ev  = cnt_up & ~cnt_down;
        dn_ev  = cnt_down & ~cnt_up;
        sel_ok = int'(digit_sel) < DIGITS;
        if (carry_en)    mode = MODE_CARRY;
        else if (max_en) mode = MODE_MAX;
        else             mode = MODE_SINGLE;

        en_ext = '0;
        for (int j = 0; j < DIGITS; j++) en_ext[j] = lim_v[j][0];

        // Ripple decided from current values: in carry mode a digit wraps
        // exactly when it is 9 going up or 0 going down.
        act    = '0;
        absorb = '0;
        prop   = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            act[j] = (sel_ok && (up_ev || dn_ev) && digit_sel == SEL_W'(j)) ||
                     (prop && mode == MODE_CARRY && en_ext[j]);
            prop   = act[j] && (up_ev ? (cnt_q[j] == BCD_MAX) : (cnt_q[j] == 4'd0));
            absorb[j] = (mode == MODE_CARRY) && en_ext[j+1];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .value     (cnt_q[g]),
            .up        (act[g] & up_ev),
            .down      (act[g] & dn_ev),
            .limit     (clamp_limit(lim_v[g])),
            .use_limit (mode == MODE_MAX),
            .next      (nxt[g]),
            .wrap      (wrap[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= nxt;
            ovf_q <= |(wrap & ~absorb);
        end
    end

    assign cnt_out = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_counter_bank.sv
// Directed plus randomized check of bcd_counter_bank against a digit-array model.
module tb_bcd_counter_bank;

    localparam int D = 6;

    logic          clk = 1'b0;
    logic          reset, cnt_up, cnt_down, clear, carry_en, max_en;
    logic [2:0]    digit_sel;
    logic [23:0]   max_in;
    logic [23:0]   cnt_out;
    logic          ovf;

    int checks = 0;
    int failures = 0;
    int m [D];
    bit m_ovf;

    bcd_counter_bank #(.DIGITS(D)) dut (
        .clk(clk), .reset(reset), .cnt_up(cnt_up), .cnt_down(cnt_down),
        .clear(clear), .digit_sel(digit_sel), .max_in(max_in),
        .carry_en(carry_en), .max_en(max_en), .cnt_out(cnt_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] packed_model();
        logic [23:0] r = '0;
        for (int j = 0; j < D; j++) r[4*j +: 4] = 4'(m[j]);
        return r;
    endfunction

    // Behavioural rules applied to the digit array for the current inputs.
    task automatic model_step();
        int sel, lim, j, old;
        bit up;
        m_ovf = 0;
        if (reset || clear) begin
            for (int k = 0; k < D; k++) m[k] = 0;
            return;
        end
        if (cnt_up == cnt_down) return;
        sel = int'(digit_sel);
        if (sel >= D) return;
        up = cnt_up;
        if (!carry_en && max_en) begin
            lim = int'(max_in[4*sel +: 4]);
            if (lim > 9) lim = 9;
            if (up) begin
                if (m[sel] >= lim) begin m[sel] = 0; m_ovf = 1; end
                else m[sel]++;
            end else begin
                if (m[sel] == 0) begin m[sel] = lim; m_ovf = 1; end
                else if (m[sel] > lim) m[sel] = lim;
                else m[sel]--;
            end
            return;
        end
        j = sel;
        forever begin
            old = m[j];
            m[j] = up ? (old + 1) % 10 : (old + 9) % 10;
            if (old != (up ? 9 : 0)) break;
            if (!carry_en) begin m_ovf = 1; break; end
            if (j == D - 1 || max_in[4*(j+1)] == 1'b0) begin m_ovf = 1; break; end
            j++;
        end
    endtask

    task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_step();
        #1;
        chk({tag, ".cnt"}, cnt_out, packed_model());
        chk({tag, ".ovf"}, {23'd0, ovf}, {23'd0, m_ovf});
    endtask

    task automatic ev(bit up, int sel, int n, string tag);
        for (int i = 0; i < n; i++) begin
            cnt_up = up; cnt_down = !up; digit_sel = 3'(sel);
            tick(tag);
        end
        cnt_up = 0; cnt_down = 0;
    endtask

    initial begin
        for (int k = 0; k < D; k++) m[k] = 0;
        reset = 1; clear = 0; cnt_up = 0; cnt_down = 0; digit_sel = 0;
        max_in = '0; carry_en = 0; max_en = 0;
        tick("reset");
        chk("reset_const", cnt_out, 24'h0);
        reset = 0;

        // SINGLE rollover
        ev(1, 0, 9, "single_up");
        chk("single_9", cnt_out, 24'h000009);
        ev(1, 0, 1, "single_wrap");
        chk("single_wrap_c", {cnt_out[22:0], ovf}, {23'h000000, 1'b1});
        ev(0, 0, 1, "single_down");
        chk("single_down_c", {cnt_out[22:0], ovf}, {23'h000009, 1'b1});

        // CARRY ripple / borrow
        clear = 1; tick("clr"); clear = 0;
        max_in = 24'h000111; carry_en = 1;
        ev(1, 1, 9, "pre"); ev(1, 0, 9, "pre");
        chk("preset_99", cnt_out, 24'h000099);
        ev(1, 0, 1, "carry");
        chk("carry_100", {cnt_out[22:0], ovf}, {23'h000100, 1'b0});
        ev(1, 0, 9, "pre"); ev(1, 1, 9, "pre"); ev(1, 2, 8, "pre");
        chk("preset_999", cnt_out, 24'h000999);
        ev(1, 0, 1, "carry_out");
        chk("carry_ovf", {cnt_out[22:0], ovf}, {23'h000000, 1'b1});
        ev(1, 2, 1, "pre");
        ev(0, 0, 1, "borrow");
        chk("borrow_099", {cnt_out[22:0], ovf}, {23'h000099, 1'b0});

        // carry_en has priority over max_en
        max_en = 1;
        ev(1, 0, 1, "both_modes");
        chk("both_modes_c", cnt_out, 24'h000100);
        carry_en = 0;

        // MAX wrap
        clear = 1; tick("clr"); clear = 0;
        max_in = 24'h000003;
        ev(1, 0, 3, "max_up");
        chk("max_3", cnt_out, 24'h000003);
        ev(1, 0, 1, "max_wrap");
        chk("max_wrap_c", {cnt_out[22:0], ovf}, {23'h000000, 1'b1});
        ev(0, 0, 1, "max_down");
        chk("max_down_c", {cnt_out[22:0], ovf}, {23'h000003, 1'b1});
        max_in = 24'h00000C;
        ev(1, 0, 7, "max_clamp");
        max_in = 24'h000000;
        ev(1, 0, 1, "lim0_a"); ev(1, 0, 1, "lim0_b"); ev(0, 0, 1, "lim0_c");
        chk("lim0_c2", {cnt_out[22:0], ovf}, {23'h000000, 1'b1});
        max_en = 0;

        // Priority and simultaneity
        ev(1, 3, 4, "pre");
        cnt_up = 1; cnt_down = 1; digit_sel = 3; tick("both_ev");
        chk("both_ev_c", cnt_out, 24'h004000);
        cnt_down = 0; digit_sel = 6; tick("sel6");
        digit_sel = 7; tick("sel7");
        chk("sel_oob_c", cnt_out, 24'h004000);
        digit_sel = 3; clear = 1; tick("clear_up");
        chk("clear_up_c", {cnt_out[22:0], ovf}, 24'h0);
        clear = 0; ev(1, 5, 2, "pre");
        reset = 1; clear = 1; cnt_up = 1; carry_en = 1; tick("reset_all");
        reset = 0; clear = 0; cnt_up = 0; carry_en = 0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(63) == 0);
            clear    = ($urandom_range(31) == 0);
            cnt_up   = $urandom_range(1);
            cnt_down = $urandom_range(1);
            digit_sel = 3'($urandom_range(7));
            carry_en = ($urandom_range(2) == 0);
            max_en   = $urandom_range(1);
            for (int k = 0; k < D; k++)
                max_in[4*k +: 4] = ($urandom_range(1) == 1) ? 4'(1 + 2*$urandom_range(4))
                                                            : 4'($urandom_range(15));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_counter_bank.md
# bcd_counter_bank

Bank of DIGITS up/down BCD digit counters that owns the live count. It sits directly upstream and downstream of the limit/mode selection stage. Its count output feeds that stage's counter-value input. It consumes that stage's limit vector, carry-mode enable and max-mode enable to decide how the selected digit wraps and whether carries ripple. It also drives a single-cycle overflow pulse for the display/status logic.

## Interface
- DIGITS, 6, number of BCD digits (4 bits each, digit 0 = least significant)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; all state cleared on the clock edge while high
- cnt_up  input  1  single-cycle count-up event
- cnt_down  input  1  single-cycle count-down event
- clear  input  1  synchronous clear of all digits
- digit_sel  input  $clog2(DIGITS)  digit that receives count events
- max_in  input  4*DIGITS  limit/carry information from mode selection stage
- carry_en  input  1  carry mode active
- max_en  input  1  max-value mode active
- cnt_out  output  4*DIGITS  current BCD count, registered
- ovf  output  1  registered one-cycle pulse: wrap or carry/borrow out of the chain

## Operation
- Reset: cnt_out = 0, ovf = 0.
- Priority per cycle: reset > clear > count event.
- clear: all digits set to 0, ovf = 0.
- Event: cnt_up xor cnt_down. Both high or both low means no change and ovf = 0.
- digit_sel >= DIGITS: event ignored, ovf = 0.
- Mode resolution, sampled in the same cycle as the event:
  - carry_en = 1 selects CARRY, regardless of max_en.
  - Otherwise max_en = 1 selects MAX.
  - Otherwise SINGLE.
- SINGLE:
  - Selected digit counts 0..9. Up 9→0, down 0→9.
  - The wrap raises ovf. Other digits are untouched.
- MAX: limit L = max_in[4*sel+:4], with L > 9 treated as 9.
  - Up: value >= L → 0 with ovf; else +1.
  - Down: value = 0 → L with ovf; value > L → L without ovf; else −1.
  - L = 0 holds the digit at 0 and pulses ovf on every event.
- CARRY: digit j is chain-enabled when max_in[4*j] = 1.
  - Selected digit always counts 0..9 with 9↔0 wrap.
  - On wrap, the carry/borrow ripples into j+1 if that digit is chain-enabled. It continues upward through consecutive enabled digits, each doing a ±1 with 9↔0 wrap, all within the same cycle.
  - ovf = 1 when a ripple would leave digit DIGITS−1 or would enter a non-enabled digit.
  - Digits below sel are never changed.
- Digit values > 9, only reachable through corrupted state: up → 0, down → 9.

## Timing
- Event in cycle N updates cnt_out and ovf at the edge ending cycle N, visible in N+1. Latency is 1; there is no pipeline.
- The full carry ripple is combinational within one cycle, DIGITS levels deep.
- ovf is high for exactly one cycle per overflowing event. Back-to-back events give back-to-back pulses.
- Mode/limit inputs are only used in cycles with an event and need no stability beyond the sampling edge.
- Mode/limit changes take effect on the next event. Digits above a newly lowered MAX limit keep their value until the next event.
- Reset or clear asserted mid-ripple has no partial effect: the whole bank goes to 0.

## Structure
- Shared package/header: BCD_MAX = 4'd9.
- Shared package/header: mode encoding MODE_SINGLE / MODE_MAX / MODE_CARRY.
- Shared package/header: DIGIT_W = 4.
- Sub-module bcd_digit: combinational next-value logic for one digit.
  - Inputs: value, up, down, limit, use_limit.
  - Outputs: next value, wrap flag.
  - Instantiated DIGITS times in a generate loop.
- The top level holds the registers, mode decode, chain-enable gating and ovf.

## Test plan
- SINGLE rollover: reset; sel = 0, 10 × cnt_up → cnt_out = 0x000000 with one ovf, in the 10th event's output cycle. Then cnt_down → 0x000009 with ovf.
- CARRY ripple: max_in = 0x000111, carry_en = 1, cnt_out preset to 0x000099 via events, sel = 0, cnt_up → 0x000100, ovf = 0. Preset 0x000999, cnt_up → 0x000000, ovf = 1 (digit 3 not enabled).
- CARRY borrow: same max_in, count 0x000100, cnt_down → 0x000099, no ovf.
- MAX wrap: max_en = 1, max_in = 0x000003, sel = 0, 4 × cnt_up → 1, 2, 3, 0, ovf on the 4th. cnt_down from 0 → 3 with ovf. Limit 0 → digit stays 0, ovf on every event.
- Priority/simultaneity: cnt_up and cnt_down together → no change. clear with cnt_up → 0x000000, ovf = 0. carry_en and max_en both high → CARRY behaviour. Reset asserted with clear and events → all zero next cycle. digit_sel = 6 → no change.
